proc_controller: RTL and testbench
==================================

// Module: proc_controller
// PURPOSE
//  Multi-cycle control unit that sequences the 4x10-bit register file, A/G ALU registers and shared data bus.
//  Accepts one instruction per PEXEC handshake and drives the register-file read/write enables and addresses.
//  Drives the ALU load and opcode controls and the bus-source select, then pulses DONE when the instruction retires.
//  Sits between the instruction source (switches/ROM) and the datapath. Owns the bus schedule exclusively.
// PARAMETERS
//  DW   10  data/instruction width
//  AW   2   register address width (2**AW registers)
//  OPW  4   opcode field width
// PORTS
//  CLKb     in   1    system clock; FSM/IR update on rising edge (register file writes on falling edge)
//  RSTb     in   1    asynchronous, active-low reset
//  PEXEC    in   1    execute request; sampled only in IDLE
//  INSTR    in   DW   instruction: [9:6]=opcode, [5:4]=Rx, [3:2]=Ry, [1:0]=reserved (ignored)
//  ENW      out  1    register-file write enable
//  WRA      out  AW   register-file write address
//  ENR0     out  1    register-file read port 0 enable
//  RDA0     out  AW   read port 0 address
//  ENR1     out  1    register-file read port 1 enable
//  RDA1     out  AW   read port 1 address
//  BUS_SEL  out  2    bus source: 0=none, 1=EXT (INSTR/Din), 2=Q0, 3=G
//  A_LD     out  1    load ALU A register from bus
//  G_LD     out  1    load ALU G register with A op Q1
//  ALU_OP   out  2    0=ADD, 1=SUB, 2=AND, 3=OR (valid when G_LD=1)
//  BUSY     out  1    high in every state except IDLE
//  DONE     out  1    one-cycle retire pulse
// BEHAVIOUR
//  - Reset (async, RSTb=0): state=IDLE, IR=0. All outputs 0 while in reset and in IDLE.
//  - Outputs are decoded combinationally from registered state+IR only; no combinational path from PEXEC/INSTR.
//  - IDLE: if PEXEC=1 at a rising CLKb edge, IR<=INSTR and state<=T1. Otherwise hold.
//  - PEXEC is ignored while BUSY=1. A held-high PEXEC starts the next instruction on the first cycle back in IDLE.
//  - Opcodes: 0=LOAD, 1=MOV, 2=ADD, 3=SUB, 4=AND, 5=OR, all others=NOP.
//  - LOAD (1 cycle): T1: BUS_SEL=EXT, ENW=1, WRA=Rx, DONE=1 -> IDLE.
//  - MOV (1 cycle): T1: ENR0=1, RDA0=Ry, BUS_SEL=Q0, ENW=1, WRA=Rx, DONE=1 -> IDLE.
//  - ALU ops (3 cycles):
//      T1: ENR0=1, RDA0=Rx, BUS_SEL=Q0, A_LD=1 -> T2
//      T2: ENR1=1, RDA1=Ry, G_LD=1, ALU_OP=opcode-2 -> T3
//      T3: BUS_SEL=G, ENW=1, WRA=Rx, DONE=1 -> IDLE
//  - NOP/undefined opcode: T1: DONE=1 only, with no ENW and no bus driver -> IDLE.
//  - Latency (PEXEC sample edge to DONE cycle): LOAD/MOV/NOP=1, ALU=3. Throughput is one instruction per (latency+1) cycles.
//  - Rx==Ry is legal. For an ALU op it reads the same register on both ports; the result overwrites it.
//  - ENW is never high outside the final cycle of an instruction. At most one bus source is selected per cycle.
//  - Reset mid-instruction aborts immediately: no ENW is issued after RSTb falls, and no DONE is pulsed for the aborted instruction.
//  - Reserved bits [1:0] have no effect.
// STRUCTURE
//  - proc_pkg holds the opcode_t enum (LOAD..OR), state_t enum (IDLE, T1, T2, T3), bus_sel_t enum, alu_op_t enum and field-slice localparams.
//  - One natural sub-module: proc_ctrl_decode, a purely combinational (state, IR) -> control-word decoder.
//  - proc_controller keeps the FSM and IR registers.
// TESTING
//  - Reset: RSTb=0 with random inputs -> all outputs 0, BUSY=0. After release with PEXEC=0 for 5 cycles, all outputs stay 0.
//  - LOAD: INSTR=10'b0000_10_00_00 with PEXEC for 1 cycle -> next cycle ENW=1, WRA=2, BUS_SEL=EXT, DONE=1; the cycle after, IDLE.
//  - MOV: INSTR=0001_11_01_00 -> single cycle with ENR0=1, RDA0=1, BUS_SEL=Q0, ENW=1, WRA=3, DONE=1.
//  - SUB: INSTR=0011_00_10_00, with R0=7 and R2=3 preloaded -> T1 A_LD/RDA0=0; T2 G_LD/RDA1=2/ALU_OP=1; T3 ENW/WRA=0/BUS_SEL=G/DONE; R0=4 after.
//  - Busy/held PEXEC: PEXEC held high across an ADD -> pulses in T1/T2 ignored; next instruction starts the cycle after DONE; DONE period=4.
//  - Abort: RSTb low during T2 of ADD -> outputs 0 immediately, no ENW ever; NOP opcode 1111 -> DONE only, ENW=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Purpose: shared types, field positions and helpers for the processor control unit.
// Contents: instruction field localparams, opcode/state/bus/ALU enums, control-word struct.
package proc_pkg;

    localparam int unsigned DW     = 10;
    localparam int unsigned AW     = 2;
    localparam int unsigned OPW    = 4;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RX_LSB = 4;
    localparam int unsigned RY_LSB = 2;

    typedef enum logic [OPW-1:0] {
        OP_LOAD = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_EXT  = 2'd1,
        BUS_Q0   = 2'd2,
        BUS_G    = 2'd3
    } bus_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    // One cycle's worth of datapath control.
    typedef struct packed {
        logic          enw;
        logic [AW-1:0] wra;
        logic          enr0;
        logic [AW-1:0] rda0;
        logic          enr1;
        logic [AW-1:0] rda1;
        bus_sel_t      bus_sel;
        logic          a_ld;
        logic          g_ld;
        alu_op_t       alu_op;
        logic          busy;
        logic          done;
    } ctrl_t;

    // ALU opcodes occupy the contiguous range ADD..OR.
    function automatic logic is_alu(input logic [OPW-1:0] op);
        return (op >= OPW'(OP_ADD)) && (op <= OPW'(OP_OR));
    endfunction

endpackage

// File: rtl/proc_if.sv
// Purpose: instruction handshake and datapath control bundle of the control unit.
// master = instruction source / datapath side, slave = proc_controller.
// Signals: PEXEC, INSTR (to controller); ENW, WRA, ENR0, RDA0, ENR1, RDA1,
//          BUS_SEL, A_LD, G_LD, ALU_OP, BUSY, DONE (from controller).
interface proc_if;
    import proc_pkg::*;

    logic          PEXEC;
    logic [DW-1:0] INSTR;
    logic          ENW;
    logic [AW-1:0] WRA;
    logic          ENR0;
    logic [AW-1:0] RDA0;
    logic          ENR1;
    logic [AW-1:0] RDA1;
    logic [1:0]    BUS_SEL;
    logic          A_LD;
    logic          G_LD;
    logic [1:0]    ALU_OP;
    logic          BUSY;
    logic          DONE;

    modport master (
        output PEXEC, INSTR,
        input  ENW, WRA, ENR0, RDA0, ENR1, RDA1, BUS_SEL, A_LD, G_LD, ALU_OP, BUSY, DONE
    );

    modport slave (
        input  PEXEC, INSTR,
        output ENW, WRA, ENR0, RDA0, ENR1, RDA1, BUS_SEL, A_LD, G_LD, ALU_OP, BUSY, DONE
    );

endinterface

// File: rtl/proc_ctrl_decode.sv
// Purpose: purely combinational (state, IR) -> control-word decoder.
// Ports: state (FSM state), ir (latched instruction), ctrl_c (control word for this cycle).
module proc_ctrl_decode
    import proc_pkg::*;
(
    input  state_t        state,
    input  logic [DW-1:0] ir,
    output ctrl_t         ctrl_c
);

    opcode_t       op;
    logic [AW-1:0] rx;
    logic [AW-1:0] ry;
    logic          unused_rsvd;

    assign op          = opcode_t'(ir[OP_LSB +: OPW]);
    assign rx          = ir[RX_LSB +: AW];
    assign ry          = ir[RY_LSB +: AW];
    assign unused_rsvd = ^ir[1:0];

    // Idle decodes to all-zero; T2/T3 are only ever reached by ALU ops.
    always_comb begin
        ctrl_c      = '0;
        ctrl_c.busy = (state != ST_IDLE);
        case (state)
            ST_T1: begin
                case (op)
                    OP_LOAD: begin
                        ctrl_c.bus_sel = BUS_EXT;
                        ctrl_c.enw     = 1'b1;
                        ctrl_c.wra     = rx;
                        ctrl_c.done    = 1'b1;
                    end
                    OP_MOV: begin
                        ctrl_c.enr0    = 1'b1;
                        ctrl_c.rda0    = ry;
                        ctrl_c.bus_sel = BUS_Q0;
                        ctrl_c.enw     = 1'b1;
                        ctrl_c.wra     = rx;
                        ctrl_c.done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl_c.enr0    = 1'b1;
                        ctrl_c.rda0    = rx;
                        ctrl_c.bus_sel = BUS_Q0;
                        ctrl_c.a_ld    = 1'b1;
                    end
                    default: ctrl_c.done = 1'b1;
                endcase
            end
            ST_T2: begin
                ctrl_c.enr1   = 1'b1;
                ctrl_c.rda1   = ry;
                ctrl_c.g_ld   = 1'b1;
                ctrl_c.alu_op = alu_op_t'(2'(ir[OP_LSB +: OPW] - OPW'(OP_ADD)));
            end
            ST_T3: begin
                ctrl_c.bus_sel = BUS_G;
                ctrl_c.enw     = 1'b1;
                ctrl_c.wra     = rx;
                ctrl_c.done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/proc_controller.sv
// Purpose: multi-cycle control unit sequencing register file, ALU A/G registers and the bus.
// Ports: CLKb (clock), RSTb (async active-low reset), ctl (proc_if slave: PEXEC/INSTR in,
//        register-file/ALU/bus controls plus BUSY/DONE out).
module proc_controller
    import proc_pkg::*;
(
    input  logic  CLKb,
    input  logic  RSTb,
    proc_if.slave ctl
);

    state_t        state;
    logic [DW-1:0] ir;
    ctrl_t         ctrl_c;

    // FSM and instruction register; PEXEC is only looked at in IDLE.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl.PEXEC) begin
                        ir    <= ctl.INSTR;
                        state <= ST_T1;
                    end
                end
                ST_T1:   state <= is_alu(ir[OP_LSB +: OPW]) ? ST_T2 : ST_IDLE;
                ST_T2:   state <= ST_T3;
                ST_T3:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    proc_ctrl_decode u_decode (
        .state  (state),
        .ir     (ir),
        .ctrl_c (ctrl_c)
    );

    assign ctl.ENW     = ctrl_c.enw;
    assign ctl.WRA     = ctrl_c.wra;
    assign ctl.ENR0    = ctrl_c.enr0;
    assign ctl.RDA0    = ctrl_c.rda0;
    assign ctl.ENR1    = ctrl_c.enr1;
    assign ctl.RDA1    = ctrl_c.rda1;
    assign ctl.BUS_SEL = ctrl_c.bus_sel;
    assign ctl.A_LD    = ctrl_c.a_ld;
    assign ctl.G_LD    = ctrl_c.g_ld;
    assign ctl.ALU_OP  = ctrl_c.alu_op;
    assign ctl.BUSY    = ctrl_c.busy;
    assign ctl.DONE    = ctrl_c.done;

endmodule

// File: tb/tb_proc_controller.sv
// Purpose: scoreboard bench for proc_controller with a small register-file/ALU model.
module tb_proc_controller;

    logic clk;
    logic rst_n;

    proc_if ifc ();

    proc_controller dut (
        .CLKb (clk),
        .RSTb (rst_n),
        .ctl  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int enw_cnt = 0;

    logic [16:0] exp_q[$];
    int          done_q[$];

    // {ENW,WRA,ENR0,RDA0,ENR1,RDA1,BUS_SEL,A_LD,G_LD,ALU_OP,BUSY,DONE}
    wire [16:0] dut_w = {ifc.ENW, ifc.WRA, ifc.ENR0, ifc.RDA0, ifc.ENR1, ifc.RDA1,
                         ifc.BUS_SEL, ifc.A_LD, ifc.G_LD, ifc.ALU_OP, ifc.BUSY, ifc.DONE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] cw(input logic enw, input logic [1:0] wra,
                                       input logic enr0, input logic [1:0] rda0,
                                       input logic enr1, input logic [1:0] rda1,
                                       input logic [1:0] bs, input logic a_ld,
                                       input logic g_ld, input logic [1:0] aop,
                                       input logic done);
        return {enw, wra, enr0, rda0, enr1, rda1, bs, a_ld, g_ld, aop, 1'b1, done};
    endfunction

    task automatic exp_load(input logic [1:0] rx);
        exp_q.push_back(cw(1, rx, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1));
    endtask

    task automatic exp_mov(input logic [1:0] rx, input logic [1:0] ry);
        exp_q.push_back(cw(1, rx, 1, ry, 0, 0, 2'd2, 0, 0, 0, 1));
    endtask

    task automatic exp_alu(input logic [1:0] rx, input logic [1:0] ry, input logic [1:0] aop);
        exp_q.push_back(cw(0, 0, 1, rx, 0, 0, 2'd2, 1, 0, 0, 0));
        exp_q.push_back(cw(0, 0, 0, 0, 1, ry, 2'd0, 0, 1, aop, 0));
        exp_q.push_back(cw(1, rx, 0, 0, 0, 0, 2'd3, 0, 0, 0, 1));
    endtask

    task automatic exp_nop();
        exp_q.push_back(cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
    endtask

    // Datapath model driven by the DUT controls.
    logic [9:0] rf[4];
    logic [9:0] a_reg, g_reg, bus_v, q1;

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = '0;
        a_reg = '0;
        g_reg = '0;
    end

    always @* begin
        case (ifc.BUS_SEL)
            2'd1:    bus_v = ifc.INSTR;
            2'd2:    bus_v = ifc.ENR0 ? rf[ifc.RDA0] : 10'h3ff;
            2'd3:    bus_v = g_reg;
            default: bus_v = '0;
        endcase
        q1 = ifc.ENR1 ? rf[ifc.RDA1] : 10'h3ff;
    end

    always @(posedge clk) begin
        if (ifc.A_LD) a_reg <= bus_v;
        if (ifc.G_LD) begin
            case (ifc.ALU_OP)
                2'd0:    g_reg <= a_reg + q1;
                2'd1:    g_reg <= a_reg - q1;
                2'd2:    g_reg <= a_reg & q1;
                default: g_reg <= a_reg | q1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (ifc.ENW === 1'b1) begin
            rf[ifc.WRA] <= bus_v;
            enw_cnt++;
        end
    end

    // Monitor: any non-idle output word is matched against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (dut_w !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ctrl: got 0x%0h expected nothing (t=%0t)", dut_w, $time);
            end else begin
                check("ctrl_word", 32'(dut_w), 32'(exp_q.pop_front()));
            end
            if (ifc.DONE === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic issue(input logic [9:0] instr, input logic [9:0] data);
        @(posedge clk); #2;
        ifc.PEXEC = 1'b1;
        ifc.INSTR = instr;
        @(posedge clk); #2;
        ifc.PEXEC = 1'b0;
        ifc.INSTR = data;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk); #1;
        check(name, 32'(dut_w), 32'd0);
    endtask

    int enw_before;

    initial begin
        rst_n     = 1'b0;
        ifc.PEXEC = 1'b0;
        ifc.INSTR = '0;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            ifc.PEXEC = 1'($urandom_range(1));
            ifc.INSTR = 10'($urandom);
            #3;
            check("reset_outputs", 32'(dut_w), 32'd0);
        end
        @(posedge clk); #2;
        ifc.PEXEC = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 5; i++) check_idle("post_reset_idle");

        // Preload R0=7 (reserved bits set), then the documented LOAD R2=3.
        issue(10'b0000_00_00_11, 10'd7);
        exp_load(2'd0);
        wait_drain("load_r0");
        check("r0_loaded", 32'(rf[0]), 32'd7);
        issue(10'b0000_10_00_00, 10'd3);
        exp_load(2'd2);
        wait_drain("load_r2");
        check_idle("load_then_idle");
        check("r2_loaded", 32'(rf[2]), 32'd3);

        // SUB R0,R2 -> 7-3.
        issue(10'b0011_00_10_00, 10'd0);
        exp_alu(2'd0, 2'd2, 2'd1);
        wait_drain("sub");
        check_idle("sub_then_idle");
        check("sub_result", 32'(rf[0]), 32'd4);

        // LOAD R1=5, MOV R3<-R1.
        issue(10'b0000_01_00_00, 10'd5);
        exp_load(2'd1);
        wait_drain("load_r1");
        issue(10'b0001_11_01_00, 10'd0);
        exp_mov(2'd3, 2'd1);
        wait_drain("mov");
        check("mov_result", 32'(rf[3]), 32'd5);

        // Held PEXEC across two ADD R2,R2 (Rx==Ry): 3 -> 6 -> 12.
        done_q.delete();
        exp_alu(2'd2, 2'd2, 2'd0);
        exp_alu(2'd2, 2'd2, 2'd0);
        @(posedge clk); #2;
        ifc.PEXEC = 1'b1;
        ifc.INSTR = 10'b0010_10_10_00;
        repeat (5) @(posedge clk);
        #2;
        ifc.PEXEC = 1'b0;
        wait_drain("held_add");
        check_idle("held_then_idle");
        check("held_add_result", 32'(rf[2]), 32'd12);
        check("held_done_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2)
            check("held_done_period", 32'(done_q[1] - done_q[0]), 32'd4);

        // AND R1,R2 -> 5&12; OR R2,R3 (reserved bits set) -> 12|5.
        issue(10'b0100_01_10_00, 10'd0);
        exp_alu(2'd1, 2'd2, 2'd2);
        wait_drain("and");
        check("and_result", 32'(rf[1]), 32'd4);
        issue(10'b0101_10_11_11, 10'd0);
        exp_alu(2'd2, 2'd3, 2'd3);
        wait_drain("or");
        check("or_result", 32'(rf[2]), 32'd13);

        // Abort ADD R1,R3 with reset in T2.
        enw_before = enw_cnt;
        exp_q.push_back(cw(0, 0, 1, 2'd1, 0, 0, 2'd2, 1, 0, 0, 0));
        issue(10'b0010_01_11_00, 10'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'(dut_w), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) check_idle("abort_idle");
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_no_enw", 32'(enw_cnt - enw_before), 32'd0);
        check("abort_r1_kept", 32'(rf[1]), 32'd4);

        // NOP opcodes 1111 and 0110: DONE only.
        enw_before = enw_cnt;
        issue(10'b1111_01_10_11, 10'd0);
        exp_nop();
        wait_drain("nop_f");
        issue(10'b0110_00_00_00, 10'd0);
        exp_nop();
        wait_drain("nop_6");
        check_idle("nop_then_idle");
        check("nop_no_enw", 32'(enw_cnt - enw_before), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
